// File: rtl/latch_ctrl_pkg.sv
// latch_ctrl_pkg: FSM state encoding and default sizing for the latch bank sequencer
package latch_ctrl_pkg;
   typedef enum logic [1:0] {IDLE, SETUP, ENABLE, HOLD} state_t;
   localparam int NUM_REQ_DEF = 4;
   localparam int DATA_W_DEF = 8;
   localparam int EN_CYCLES_DEF = 2;
endpackage

// File: rtl/latch_bank_sequencer_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, lowest requester at or above ptr wins
module rr_arbiter import latch_ctrl_pkg::*; #(
   parameter int N = NUM_REQ_DEF,
   localparam int IW = $clog2(N)
)(
   input logic [N-1:0] req,
   input logic [IW-1:0] ptr,
   output logic [N-1:0] grant,
   output logic [IW-1:0] idx
);
   int j;
   // scan upward from ptr with wrap-around; the first set request takes the grant
   always_comb begin
      grant = '0;
      idx = '0;
      j = 0;
      for (int k = 0; k < N; k++) begin
         j = (int'(ptr) + k) % N;
         if (grant == '0 && req[j]) begin
            grant[j] = 1'b1;
            idx = IW'(j);
         end
      end
   end
endmodule

// File: rtl/latch_bank_sequencer.sv
// latch_bank_sequencer: round-robin writer of a shared D-latch bank with D held around every C pulse.
// Optional LATCH_READBACK_EN: compare latch_q against latch_d in HOLD and raise sticky verify_err.
module latch_bank_sequencer import latch_ctrl_pkg::*; #(
   parameter int NUM_REQ = NUM_REQ_DEF,
   parameter int DATA_W = DATA_W_DEF,
   parameter int EN_CYCLES = EN_CYCLES_DEF,
   localparam int IW = $clog2(NUM_REQ),
   localparam int CW = $clog2(EN_CYCLES + 1)
)(
   input logic clk,
   input logic rst,
   input logic [NUM_REQ-1:0] req,
   input logic [NUM_REQ*DATA_W-1:0] wdata,
   output logic [NUM_REQ-1:0] ack,
   output logic [DATA_W-1:0] latch_d,
   output logic latch_c,
   input logic [DATA_W-1:0] latch_q,
   output logic busy,
   output logic [IW-1:0] grant_id,
   output logic verify_err
);
   state_t state;
   logic [IW-1:0] rr_ptr;
   logic [IW-1:0] win_id;
   logic [NUM_REQ-1:0] win;
   logic [CW-1:0] cnt;

   rr_arbiter #(.N(NUM_REQ)) u_arb (
      .req(req),
      .ptr(rr_ptr),
      .grant(win),
      .idx(win_id)
   );

   // sequencer FSM; latch_c, ack and busy are registered from the state being entered
   always_ff @(posedge clk or posedge rst)
      if (rst) begin
         state <= IDLE;
         latch_d <= '0;
         latch_c <= 1'b0;
         ack <= '0;
         busy <= 1'b0;
         grant_id <= '0;
         rr_ptr <= '0;
         cnt <= '0;
      end else begin
         ack <= '0;
         case (state)
            IDLE:
               if (|win) begin
                  state <= SETUP;
                  latch_d <= wdata[int'(win_id)*DATA_W +: DATA_W];
                  grant_id <= win_id;
                  busy <= 1'b1;
               end
            SETUP: begin
               state <= ENABLE;
               cnt <= CW'(EN_CYCLES - 1);
               latch_c <= 1'b1;
            end
            ENABLE:
               if (cnt == '0) begin
                  state <= HOLD;
                  latch_c <= 1'b0;
                  ack <= NUM_REQ'(1) << grant_id;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            HOLD: begin
               state <= IDLE;
               busy <= 1'b0;
               rr_ptr <= (grant_id == IW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
            end
            default: state <= IDLE;
         endcase
      end

`ifdef LATCH_READBACK_EN
   // sticky flag: the bank did not return the word just written
   always_ff @(posedge clk or posedge rst)
      if (rst)
         verify_err <= 1'b0;
      else if (state == HOLD && latch_q != latch_d)
         verify_err <= 1'b1;
`else
   logic unused_q;
   assign unused_q = ^latch_q;
   assign verify_err = 1'b0;
`endif
endmodule
